// File: rtl/flash_loader.sv
// flash_loader: after a startup delay, issues a single SPI READ (0x03 + 24-bit
// address) to a mode-0 serial flash, streams FlashTransferBytes bytes back and
// writes them as little-endian 32-bit words to a RAM port starting at address 0.
//
// Ports:
//   clk, rst          single clock, synchronous active-high reset
//   done              high once every word has been written (held until rst)
//   flash_clk         SPI clock (clk/2 while shifting, low otherwise)
//   flash_miso        SPI data from flash, sampled at the end of flash_clk high
//   flash_mosi        SPI data to flash, changes only while flash_clk is low
//   flash_cs_n        SPI chip select, active low, held for the whole burst
//   ramio_enable      one-cycle write request
//   ramio_read_type   constant 3'b000
//   ramio_write_type  2'b11 while ramio_enable is high, else 2'b00
//   ramio_address     RAM byte address of the word being written
//   ramio_data_in     word being written
//   ramio_busy        RAM interface busy
//   state_dbg         current FSM state, for debug/checkers
//
// RAM handshake: a write is offered only when ramio_busy is low; ramio_enable
// is high for exactly one cycle with address/data stable. The cycle after the
// pulse is skipped (the RAM may not have raised busy yet), then the loader
// waits for ramio_busy to fall before reading the next word from flash.
module flash_loader #(
  parameter int unsigned StartupWaitCycles  = 1_000_000,
  parameter logic [31:0] FlashFromAddress   = 32'h0,
  parameter int unsigned FlashTransferBytes = 4096
) (
  input  logic        clk,
  input  logic        rst,
  output logic        done,
  output logic        flash_clk,
  input  logic        flash_miso,
  output logic        flash_mosi,
  output logic        flash_cs_n,
  output logic        ramio_enable,
  output logic [2:0]  ramio_read_type,
  output logic [1:0]  ramio_write_type,
  output logic [31:0] ramio_address,
  output logic [31:0] ramio_data_in,
  input  logic        ramio_busy,
  output logic [2:0]  state_dbg
);

  typedef enum logic [2:0] {
    STARTUP_WAIT = 3'd0,
    SEND_CMD     = 3'd1,
    READ_BYTE    = 3'd2,
    WRITE_WORD   = 3'd3,
    WAIT_BUSY    = 3'd4,
    DONE         = 3'd5
  } state_t;

  localparam logic [31:0] Cmd        = {8'h03, FlashFromAddress[23:0]};
  localparam logic [31:0] WaitLast   = (StartupWaitCycles > 0) ? 32'(StartupWaitCycles - 1) : 32'd0;
  localparam logic [31:0] LastAddr   = (FlashTransferBytes >= 4) ? 32'(FlashTransferBytes - 4) : 32'd0;
  localparam bit          NoTransfer = (FlashTransferBytes == 0);

  state_t      state, next_state;
  logic [31:0] wait_cnt;
  logic [4:0]  bit_cnt;     // command bit index, or bit index within a byte
  logic        phase;       // 0: flash_clk low cycle, 1: flash_clk high cycle
  logic [1:0]  byte_idx;    // byte position within the current word
  logic [6:0]  shreg;       // first 7 bits of the byte; the 8th comes from miso
  logic        skip;        // WAIT_BUSY ignores busy for one cycle

  logic wait_done, last_word;
  assign wait_done = (wait_cnt == WaitLast);
  assign last_word = (ramio_address == LastAddr);

  assign ramio_read_type = 3'b000;
  assign state_dbg       = state;

  always_ff @(posedge clk) begin
    if (rst) state <= STARTUP_WAIT;
    else     state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      STARTUP_WAIT: if (wait_done) next_state = NoTransfer ? DONE : SEND_CMD;
      SEND_CMD:     if (phase && bit_cnt == 5'd31) next_state = READ_BYTE;
      READ_BYTE:    if (phase && bit_cnt[2:0] == 3'd7 && byte_idx == 2'd3) next_state = WRITE_WORD;
      WRITE_WORD:   if (!ramio_busy) next_state = WAIT_BUSY;
      WAIT_BUSY:    if (!skip && !ramio_busy) next_state = last_word ? DONE : READ_BYTE;
      DONE:         next_state = DONE;
      default:      next_state = STARTUP_WAIT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wait_cnt         <= 32'd0;
      bit_cnt          <= 5'd0;
      phase            <= 1'b0;
      byte_idx         <= 2'd0;
      shreg            <= 7'd0;
      skip             <= 1'b0;
      done             <= 1'b0;
      flash_cs_n       <= 1'b1;
      flash_clk        <= 1'b0;
      flash_mosi       <= 1'b0;
      ramio_enable     <= 1'b0;
      ramio_write_type <= 2'b00;
      ramio_address    <= 32'd0;
      ramio_data_in    <= 32'd0;
    end else begin
      case (state)
        STARTUP_WAIT: begin
          wait_cnt <= wait_cnt + 32'd1;
          if (wait_done) begin
            if (NoTransfer) begin
              done <= 1'b1;
            end else begin
              // First command bit is presented with cs_n falling.
              flash_cs_n <= 1'b0;
              flash_mosi <= Cmd[31];
              bit_cnt    <= 5'd0;
              phase      <= 1'b0;
            end
          end
        end
        SEND_CMD: begin
          if (!phase) begin
            flash_clk <= 1'b1;
            phase     <= 1'b1;
          end else begin
            flash_clk <= 1'b0;
            phase     <= 1'b0;
            if (bit_cnt == 5'd31) begin
              flash_mosi <= 1'b0;
              bit_cnt    <= 5'd0;
              byte_idx   <= 2'd0;
            end else begin
              bit_cnt    <= bit_cnt + 5'd1;
              flash_mosi <= Cmd[5'd30 - bit_cnt];
            end
          end
        end
        READ_BYTE: begin
          if (!phase) begin
            flash_clk <= 1'b1;
            phase     <= 1'b1;
          end else begin
            flash_clk <= 1'b0;
            phase     <= 1'b0;
            shreg     <= {shreg[5:0], flash_miso};
            if (bit_cnt[2:0] == 3'd7) begin
              ramio_data_in[{byte_idx, 3'b000} +: 8] <= {shreg, flash_miso};
              byte_idx <= byte_idx + 2'd1;
              bit_cnt  <= 5'd0;
            end else begin
              bit_cnt <= bit_cnt + 5'd1;
            end
          end
        end
        WRITE_WORD: begin
          if (!ramio_busy) begin
            ramio_enable     <= 1'b1;
            ramio_write_type <= 2'b11;
            skip             <= 1'b1;
          end
        end
        WAIT_BUSY: begin
          ramio_enable     <= 1'b0;
          ramio_write_type <= 2'b00;
          if (skip) begin
            skip <= 1'b0;
          end else if (!ramio_busy) begin
            if (last_word) begin
              flash_cs_n <= 1'b1;
              done       <= 1'b1;
            end else begin
              ramio_address <= ramio_address + 32'd4;
            end
          end
        end
        DONE: begin
          flash_cs_n <= 1'b1;
          flash_clk  <= 1'b0;
          done       <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_flash_loader.sv
// Bench for flash_loader: main instance (4-cycle startup, 8 bytes from 0x100)
// and a zero-length instance sharing clock and reset. A flash model answers
// the READ command; a monitor pops expected {address,data} pairs from exp_q on
// every ramio_enable pulse and checks SPI/RAM protocol rules each cycle.
module tb_flash_loader;

  // clock / reset
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst = 1'b1;

  logic        flash_miso = 1'b0;
  logic        ramio_busy = 1'b0;
  logic        done, flash_clk, flash_mosi, flash_cs_n, ramio_enable;
  logic [2:0]  ramio_read_type, state_dbg;
  logic [1:0]  ramio_write_type;
  logic [31:0] ramio_address, ramio_data_in;

  logic        z_done, z_fclk, z_mosi, z_cs_n, z_en;
  logic [2:0]  z_rt, z_state;
  logic [1:0]  z_wt;
  logic [31:0] z_addr, z_data;
  logic        z_miso = 1'b0;
  logic        z_busy = 1'b0;

  flash_loader #(.StartupWaitCycles(4), .FlashFromAddress(32'h0000_0100), .FlashTransferBytes(8)) dut (
    .clk(clk), .rst(rst), .done(done), .flash_clk(flash_clk), .flash_miso(flash_miso),
    .flash_mosi(flash_mosi), .flash_cs_n(flash_cs_n), .ramio_enable(ramio_enable),
    .ramio_read_type(ramio_read_type), .ramio_write_type(ramio_write_type),
    .ramio_address(ramio_address), .ramio_data_in(ramio_data_in),
    .ramio_busy(ramio_busy), .state_dbg(state_dbg)
  );

  flash_loader #(.StartupWaitCycles(4), .FlashFromAddress(32'h0000_0100), .FlashTransferBytes(0)) u_zero (
    .clk(clk), .rst(rst), .done(z_done), .flash_clk(z_fclk), .flash_miso(z_miso),
    .flash_mosi(z_mosi), .flash_cs_n(z_cs_n), .ramio_enable(z_en),
    .ramio_read_type(z_rt), .ramio_write_type(z_wt),
    .ramio_address(z_addr), .ramio_data_in(z_data),
    .ramio_busy(z_busy), .state_dbg(z_state)
  );

  // scoreboard
  logic [63:0] exp_q[$];
  int n_checks = 0;
  int n_fail   = 0;

  function automatic void check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endfunction

  // flash model: counts flash_clk rising edges while selected
  logic [7:0]  mem [0:7] = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88};
  int          rise_cnt = 0;
  int          k;
  logic        prev_fclk = 1'b0;
  logic [31:0] cmd_rx = 32'd0;
  logic [7:0]  byte_v;

  always @(negedge clk) begin
    if (flash_cs_n) begin
      rise_cnt   = 0;
      flash_miso = 1'b0;
    end else if (flash_clk && !prev_fclk) begin
      if (rise_cnt < 32) begin
        cmd_rx = {cmd_rx[30:0], flash_mosi};
        if (rise_cnt == 31) check("spi_command", cmd_rx, 32'h0300_0100);
      end else begin
        k          = rise_cnt - 32;
        byte_v     = mem[(k / 8) % 8];
        flash_miso = byte_v[7 - (k % 8)];
      end
      rise_cnt++;
    end
    prev_fclk = flash_clk;
  end

  // monitor
  logic prev_en = 1'b0, prev_cs = 1'b1, prev_mosi = 1'b0, prev_fclk_m = 1'b0;
  int   en_cnt = 0, z_en_cnt = 0, z_cs_low = 0;
  logic [63:0] e;

  always @(negedge clk) begin
    check("write_type", ramio_write_type, ramio_enable ? 2'b11 : 2'b00);
    check("read_type", ramio_read_type, 3'b000);
    if (ramio_enable) begin
      en_cnt++;
      check("enable_width", prev_en, 1'b0);
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_write: got %0h@%0h, expected none", ramio_data_in, ramio_address);
      end else begin
        e = exp_q.pop_front();
        check("write_addr", ramio_address, e[63:32]);
        check("write_data", ramio_data_in, e[31:0]);
      end
    end
    if (flash_clk !== prev_fclk_m) check("fclk_toggle_while_cs", flash_cs_n & prev_cs, 1'b0);
    if (flash_mosi !== prev_mosi)  check("mosi_change_fclk_low", flash_clk, 1'b0);
    if (!z_cs_n) z_cs_low++;
    if (z_en)    z_en_cnt++;
    prev_en     = ramio_enable;
    prev_cs     = flash_cs_n;
    prev_mosi   = flash_mosi;
    prev_fclk_m = flash_clk;
  end

  // driver tasks
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_rise(input int target, input int budget, input string name);
    int b = budget;
    while (rise_cnt != target && b > 0) begin step(); b--; end
    check(name, 64'(rise_cnt), 64'(target));
  endtask

  task automatic wait_enable(input int budget);
    int b = budget;
    while (ramio_enable !== 1'b1 && b > 0) begin step(); b--; end
    check("wait_enable", ramio_enable, 1'b1);
  endtask

  task automatic wait_done(input int budget, input string name);
    int b = budget;
    while (done !== 1'b1 && b > 0) begin step(); b--; end
    check(name, done, 1'b1);
  endtask

  task automatic push_words();
    exp_q.push_back({32'h0000_0000, 32'h4433_2211});
    exp_q.push_back({32'h0000_0004, 32'h8877_6655});
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) step();
    check("rst_done", done, 1'b0);
    check("rst_cs_n", flash_cs_n, 1'b1);
    check("rst_fclk", flash_clk, 1'b0);
    check("rst_mosi", flash_mosi, 1'b0);
    check("rst_enable", ramio_enable, 1'b0);
    check("rst_addr", ramio_address, 32'd0);
    check("rst_data", ramio_data_in, 32'd0);
    check("rst_zero_done", z_done, 1'b0);

    // normal run with a 10-cycle stall and busy after the first pulse
    push_words();
    en_cnt = 0;
    rst = 1'b0;
    repeat (3) step();
    check("startup_cs_hold", flash_cs_n, 1'b1);
    check("zero_done_early", z_done, 1'b0);
    step();
    check("startup_cs_low", flash_cs_n, 1'b0);
    check("zero_done_on_time", z_done, 1'b1);

    wait_rise(64, 300, "first_word_rises");
    ramio_busy = 1'b1;
    for (int i = 0; i < 10; i++) begin
      check("stall_enable", ramio_enable, 1'b0);
      check("stall_fclk", flash_clk, 1'b0);
      step();
    end
    ramio_busy = 1'b0;
    wait_enable(20);
    ramio_busy = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      check("busy_after_pulse_fclk", flash_clk, 1'b0);
    end
    check("busy_after_pulse_no_read", 64'(rise_cnt), 64'd64);
    ramio_busy = 1'b0;
    wait_done(400, "run1_done");
    step();
    check("run1_cs_n", flash_cs_n, 1'b1);
    check("run1_fclk", flash_clk, 1'b0);
    check("run1_done_held", done, 1'b1);
    check("run1_queue_empty", 64'(exp_q.size()), 64'd0);
    check("run1_pulses", 64'(en_cnt), 64'd2);
    check("zero_pulses", 64'(z_en_cnt), 64'd0);
    check("zero_cs_never_low", 64'(z_cs_low), 64'd0);

    // reset during the 2nd byte of the 1st word, then full restart
    rst = 1'b1;
    step();
    check("reset_clears_done", done, 1'b0);
    rst = 1'b0;
    push_words();
    en_cnt = 0;
    wait_rise(44, 200, "second_byte_rises");
    rst = 1'b1;
    step();
    check("abort_cs_n", flash_cs_n, 1'b1);
    check("abort_fclk", flash_clk, 1'b0);
    check("abort_enable", ramio_enable, 1'b0);
    check("abort_pulses", 64'(en_cnt), 64'd0);
    exp_q.delete();
    step();
    rst = 1'b0;
    push_words();
    wait_done(400, "run2_done");
    step();
    check("run2_queue_empty", 64'(exp_q.size()), 64'd0);
    check("run2_pulses", 64'(en_cnt), 64'd2);
    check("run2_cs_n", flash_cs_n, 1'b1);
    check("zero_done_final", z_done, 1'b1);
    check("zero_cs_never_low_final", 64'(z_cs_low), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
